// File: rtl/wave_step_sequencer.sv
// Step-table scheduler for the wave generator: plays entries 0..last_idx.
// Ports: table write (wr_*), start/stop/loop/last_idx control,
// period_tick timing input, cfg valid/ready handshake, gen_en, status.
module wave_step_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int PW    = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [1:0]    wr_wave,
  input  logic [PW-1:0] wr_incr,
  input  logic [DW-1:0] wr_dur,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic [AW-1:0] last_idx,
  input  logic          period_tick,
  input  logic          cfg_ready,
  output logic          cfg_valid,
  output logic [1:0]    wave_sel,
  output logic [PW-1:0] phase_incr,
  output logic          gen_en,
  output logic [AW-1:0] step_idx,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RUN,
    FINISH
  } state_t;

  state_t state, state_nx;

  logic [1:0]    tab_wave [DEPTH];
  logic [PW-1:0] tab_incr [DEPTH];
  logic [DW-1:0] tab_dur  [DEPTH];

  logic          loop_q;
  logic [AW-1:0] last_q;
  logic [DW-1:0] cnt;
  logic [1:0]    wave_q;
  logic [PW-1:0] incr_q;

  logic hs;
  logic step_end;
  logic at_last;
  logic go;

  always_comb begin
    go       = (state == IDLE) && start && !stop;
    hs       = (state == ISSUE) && cfg_ready;
    step_end = (state == RUN) && period_tick
               && (cnt == DW'(1));
    at_last  = (step_idx == last_q);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (go) state_nx = ISSUE;
      end
      ISSUE: begin
        if (stop)    state_nx = IDLE;
        else if (hs) state_nx = RUN;
      end
      RUN: begin
        if (stop) begin
          state_nx = IDLE;
        end else if (step_end) begin
          if (at_last && !loop_q) state_nx = FINISH;
          else                    state_nx = ISSUE;
        end
      end
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // In ISSUE the table is shown directly so a same-cycle
  // write+start is visible; otherwise the accepted values hold.
  always_comb begin
    cfg_valid  = (state == ISSUE);
    busy       = (state != IDLE);
    done       = (state == FINISH);
    wave_sel   = wave_q;
    phase_incr = incr_q;
    if (state == ISSUE) begin
      wave_sel   = tab_wave[step_idx];
      phase_incr = tab_incr[step_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      loop_q   <= 1'b0;
      last_q   <= '0;
      step_idx <= '0;
      cnt      <= '0;
      wave_q   <= '0;
      incr_q   <= '0;
      gen_en   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tab_wave[i] <= '0;
        tab_incr[i] <= '0;
        tab_dur[i]  <= '0;
      end
    end else begin
      state <= state_nx;
      if ((state == IDLE) && wr_en) begin
        tab_wave[wr_addr] <= wr_wave;
        tab_incr[wr_addr] <= wr_incr;
        tab_dur[wr_addr]  <= wr_dur;
      end
      if (go) begin
        loop_q   <= loop;
        last_q   <= last_idx;
        step_idx <= '0;
      end
      if ((state != IDLE) && stop) begin
        gen_en <= 1'b0;
      end else if (hs) begin
        wave_q <= tab_wave[step_idx];
        incr_q <= tab_incr[step_idx];
        // Zero duration plays as one period.
        cnt    <= (tab_dur[step_idx] == '0)
                  ? DW'(1) : tab_dur[step_idx];
        gen_en <= 1'b1;
      end else if ((state == RUN) && period_tick) begin
        cnt <= cnt - DW'(1);
        if (step_end) begin
          if (!at_last)    step_idx <= step_idx + AW'(1);
          else if (loop_q) step_idx <= '0;
          else             gen_en   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_wave_step_sequencer.sv
// Directed self-checking bench for wave_step_sequencer.
// Drives and samples 1 time unit after each rising edge.
module tb_wave_step_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [1:0] wr_wave;
  logic [7:0] wr_incr;
  logic [7:0] wr_dur;
  logic       start;
  logic       stop;
  logic       loop;
  logic [2:0] last_idx;
  logic       period_tick;
  logic       cfg_ready;
  logic       cfg_valid;
  logic [1:0] wave_sel;
  logic [7:0] phase_incr;
  logic       gen_en;
  logic [2:0] step_idx;
  logic       busy;
  logic       done;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int done_ref;

  wave_step_sequencer dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_wave(wr_wave), .wr_incr(wr_incr),
    .wr_dur(wr_dur), .start(start),
    .stop(stop), .loop(loop),
    .last_idx(last_idx),
    .period_tick(period_tick),
    .cfg_ready(cfg_ready),
    .cfg_valid(cfg_valid),
    .wave_sel(wave_sel),
    .phase_incr(phase_incr),
    .gen_en(gen_en), .step_idx(step_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a,
                    input logic [1:0] w,
                    input logic [7:0] inc,
                    input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a;
    wr_wave = w; wr_incr = inc; wr_dur = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic tick();
    period_tick = 1'b1;
    cyc();
    period_tick = 1'b0;
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_valid"}, 32'(cfg_valid), 0);
    chk({tag, "_gen"},   32'(gen_en), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_idx"},   32'(step_idx), 0);
    chk({tag, "_wave"},  32'(wave_sel), 0);
    chk({tag, "_incr"},  32'(phase_incr), 0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0;
    wr_wave = '0; wr_incr = '0; wr_dur = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0;
    last_idx = '0; period_tick = 1'b0;
    cfg_ready = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    outs_zero("rst0");

    // One-shot, two steps
    wr(3'd0, 2'd1, 8'h10, 8'd3);
    wr(3'd1, 2'd2, 8'h20, 8'd2);
    last_idx = 3'd1; loop = 1'b0;
    done_ref = done_cnt;
    start = 1'b1; cyc(); start = 1'b0;
    chk("os_valid0", 32'(cfg_valid), 1);
    chk("os_wave0", 32'(wave_sel), 1);
    chk("os_incr0", 32'(phase_incr), 32'h10);
    chk("os_gen0", 32'(gen_en), 0);
    chk("os_busy0", 32'(busy), 1);
    cyc();
    chk("os_run_gen", 32'(gen_en), 1);
    chk("os_run_valid", 32'(cfg_valid), 0);
    chk("os_run_wave", 32'(wave_sel), 1);
    tick(); tick();
    chk("os_noiss", 32'(cfg_valid), 0);
    tick();
    chk("os_valid1", 32'(cfg_valid), 1);
    chk("os_wave1", 32'(wave_sel), 2);
    chk("os_incr1", 32'(phase_incr), 32'h20);
    chk("os_idx1", 32'(step_idx), 1);
    chk("os_gen1", 32'(gen_en), 1);
    cyc();
    tick();
    chk("os_nodone", 32'(done), 0);
    tick();
    chk("os_done", 32'(done), 1);
    chk("os_fin_gen", 32'(gen_en), 0);
    chk("os_fin_busy", 32'(busy), 1);
    chk("os_fin_wave", 32'(wave_sel), 2);
    cyc();
    chk("os_done_off", 32'(done), 0);
    chk("os_idle", 32'(busy), 0);
    chk("os_done_cnt", 32'(done_cnt - done_ref), 1);

    // Handshake stall
    cfg_ready = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("st_valid", 32'(cfg_valid), 1);
      chk("st_wave", 32'(wave_sel), 1);
      chk("st_incr", 32'(phase_incr), 32'h10);
      chk("st_gen", 32'(gen_en), 0);
      cyc();
    end
    cfg_ready = 1'b1;
    cyc();
    chk("st_gen_on", 32'(gen_en), 1);
    chk("st_run", 32'(cfg_valid), 0);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("st_stop_busy", 32'(busy), 0);
    chk("st_stop_gen", 32'(gen_en), 0);

    // Looping playback, 10 ticks
    loop = 1'b1;
    done_ref = done_cnt;
    start = 1'b1; cyc(); start = 1'b0;
    chk("lp_idx0", 32'(step_idx), 0);
    cyc();
    tick(); tick(); tick();
    chk("lp_idx1", 32'(step_idx), 1);
    cyc();
    tick(); tick();
    chk("lp_idx2", 32'(step_idx), 0);
    chk("lp_wrap_valid", 32'(cfg_valid), 1);
    cyc();
    tick(); tick(); tick();
    chk("lp_idx3", 32'(step_idx), 1);
    cyc();
    tick(); tick();
    chk("lp_idx4", 32'(step_idx), 0);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("lp_stop_busy", 32'(busy), 0);
    chk("lp_stop_gen", 32'(gen_en), 0);
    chk("lp_stop_valid", 32'(cfg_valid), 0);
    cyc();
    chk("lp_no_done", 32'(done_cnt - done_ref), 0);

    // Zero duration ends after one tick
    loop = 1'b0; last_idx = 3'd0;
    wr(3'd0, 2'd3, 8'h44, 8'd0);
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    chk("zd_run", 32'(gen_en), 1);
    tick();
    chk("zd_done", 32'(done), 1);
    cyc();

    // Writes during playback are ignored
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    wr(3'd0, 2'd0, 8'h99, 8'd5);
    tick();
    chk("bp_done", 32'(done), 1);
    cyc();
    start = 1'b1; cyc(); start = 1'b0;
    chk("bp_wave", 32'(wave_sel), 3);
    chk("bp_incr", 32'(phase_incr), 32'h44);
    cyc(); tick(); cyc();

    // Start plus stop in IDLE stays idle
    start = 1'b1; stop = 1'b1; cyc();
    start = 1'b0; stop = 1'b0;
    chk("ss_idle", 32'(busy), 0);
    chk("ss_valid", 32'(cfg_valid), 0);

    // Same-cycle write and start
    wr_en = 1'b1; wr_addr = 3'd0; wr_wave = 2'd2;
    wr_incr = 8'h55; wr_dur = 8'd1;
    start = 1'b1; cyc();
    wr_en = 1'b0; start = 1'b0;
    chk("ws_wave", 32'(wave_sel), 2);
    chk("ws_incr", 32'(phase_incr), 32'h55);

    // Reset mid-RUN clears table and outputs
    cyc();
    chk("rr_run", 32'(gen_en), 1);
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    outs_zero("rr");
    start = 1'b1; cyc(); start = 1'b0;
    chk("rr_valid", 32'(cfg_valid), 1);
    chk("rr_tab_wave", 32'(wave_sel), 0);
    chk("rr_tab_incr", 32'(phase_incr), 0);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("rr_stop", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
